// File: rtl/bit_aligner_barrel.sv
// Word/bit aligner: barrel shifter with sync-word search, verify, lock and loss tracking.
// Optional inverted-stream detection is enabled by defining BIT_ALIGNER_POLARITY_DETECT_EN.
module bit_aligner_barrel #(
    parameter int unsigned    W          = 32,
    parameter logic [W-1:0]   SYNC_WORD  = W'(32'hEB94_BDA3),
    parameter logic [W-1:0]   IDLE_WORD  = W'(32'h0707_0707),
    parameter int unsigned    SEARCH_WIN = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         i_rx_data,
    input  logic                 i_rx_valid,
    input  logic                 i_realign_req,
    input  logic [6:0]           cfg_err_th,
    input  logic [7:0]           cfg_verify_cnt,
    input  logic [19:0]          cfg_soft_to,
    input  logic [19:0]          cfg_hard_to,
    output logic [W-1:0]         o_data,
    output logic                 o_data_valid,
    output logic [$clog2(W)-1:0] o_offset,
    output logic [1:0]           o_state,
    output logic                 o_locked,
    output logic                 o_locked_soft,
    output logic                 o_polarity
);

    localparam int unsigned OW  = $clog2(W);
    localparam int unsigned PW  = $clog2(W + 1);
    localparam int unsigned WCW = $clog2(SEARCH_WIN + 1);
    localparam int unsigned LW  = 20;

`ifdef BIT_ALIGNER_POLARITY_DETECT_EN
    localparam bit POL_EN = 1'b1;
`else
    localparam bit POL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        VERIFY    = 2'd1,
        LOCKED    = 2'd2,
        SOFT_LOSS = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  offset_q, offset_d;
    logic [WCW-1:0] win_q, win_d;
    logic [7:0]     vcnt_q, vcnt_d;
    logic [LW-1:0]  loss_q, loss_d;
    logic           pol_q, pol_d;
    logic [W-1:0]   prev_q, data_q;
    logic           dvalid_q, locked_q, soft_q;

    logic [W-1:0]   aligned_raw, aligned_eff;
    logic [PW-1:0]  dist_raw, dist_eff, dist_inv;
    logic           match_pos, match_neg, match_eff, good;
    logic [OW-1:0]  next_offset;
    logic [LW-1:0]  loss_inc, soft_th, hard_th;
    logic           soft_hit, hard_hit, win_last;

    function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(W); i++) n = n + PW'(v[i]);
        return n;
    endfunction

    // Barrel window and header/idle classification of the current aligned word
    always_comb begin
        aligned_raw = W'({i_rx_data, prev_q} >> offset_q);
        aligned_eff = pol_q ? ~aligned_raw : aligned_raw;
        dist_raw    = popcount(aligned_raw ^ SYNC_WORD);
        dist_eff    = popcount(aligned_eff ^ SYNC_WORD);
        dist_inv    = PW'(W) - dist_raw;
        match_pos   = i_rx_valid && (8'(dist_raw) <= {1'b0, cfg_err_th});
        match_neg   = POL_EN && i_rx_valid && (8'(dist_inv) <= {1'b0, cfg_err_th});
        match_eff   = i_rx_valid && (8'(dist_eff) <= {1'b0, cfg_err_th});
        good        = i_rx_valid && (match_eff || (aligned_eff == IDLE_WORD));
        next_offset = (offset_q == OW'(W - 1)) ? '0 : offset_q + OW'(1);
        loss_inc    = (&loss_q) ? loss_q : loss_q + LW'(1);
        soft_th     = (cfg_soft_to == '0) ? LW'(1) : cfg_soft_to;
        hard_th     = (cfg_hard_to == '0) ? LW'(1) : cfg_hard_to;
        soft_hit    = (21'(loss_q) + 21'd1) >= 21'(soft_th);
        hard_hit    = (21'(loss_q) + 21'd1) >= 21'(hard_th);
        win_last    = (win_q == WCW'(SEARCH_WIN - 1));
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        win_d    = win_q;
        vcnt_d   = vcnt_q;
        loss_d   = loss_q;
        pol_d    = pol_q;
        case (state_q)
            SEARCH: begin
                if (match_pos || match_neg) begin
                    pol_d = !match_pos;
                    win_d = '0;
                    if (cfg_verify_cnt <= 8'd1) begin
                        state_d = LOCKED;
                        vcnt_d  = '0;
                    end else begin
                        state_d = VERIFY;
                        vcnt_d  = 8'd1;
                    end
                end else if (i_rx_valid) begin
                    if (win_last) begin
                        win_d    = '0;
                        offset_d = next_offset;
                    end else begin
                        win_d = win_q + WCW'(1);
                    end
                end
            end
            VERIFY: begin
                if (match_eff) begin
                    win_d = '0;
                    if ((9'(vcnt_q) + 9'd1) >= 9'(cfg_verify_cnt)) begin
                        state_d = LOCKED;
                        vcnt_d  = '0;
                        loss_d  = '0;
                    end else begin
                        vcnt_d = vcnt_q + 8'd1;
                    end
                end else if (i_rx_valid) begin
                    if (win_last) begin
                        state_d  = SEARCH;
                        win_d    = '0;
                        vcnt_d   = '0;
                        offset_d = next_offset;
                    end else begin
                        win_d = win_q + WCW'(1);
                    end
                end
            end
            LOCKED: begin
                if (good) begin
                    loss_d = '0;
                end else if (soft_hit) begin
                    state_d = SOFT_LOSS;
                    loss_d  = '0;
                end else begin
                    loss_d = loss_inc;
                end
            end
            SOFT_LOSS: begin
                if (good) begin
                    state_d = LOCKED;
                    loss_d  = '0;
                end else if (hard_hit) begin
                    // Offset is kept so the new search starts where the link was
                    state_d = SEARCH;
                    loss_d  = '0;
                    win_d   = '0;
                    vcnt_d  = '0;
                end else begin
                    loss_d = loss_inc;
                end
            end
            default: state_d = SEARCH;
        endcase
        if (i_realign_req) begin
            state_d  = SEARCH;
            offset_d = '0;
            win_d    = '0;
            vcnt_d   = '0;
            loss_d   = '0;
            pol_d    = 1'b0;
        end
    end

    // FSM and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            offset_q <= '0;
            win_q    <= '0;
            vcnt_q   <= '0;
            loss_q   <= '0;
            pol_q    <= 1'b0;
            locked_q <= 1'b0;
            soft_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            win_q    <= win_d;
            vcnt_q   <= vcnt_d;
            loss_q   <= loss_d;
            pol_q    <= pol_d;
            locked_q <= (state_d == LOCKED);
            soft_q   <= (state_d == LOCKED) || (state_d == SOFT_LOSS);
        end
    end

    // Datapath: previous-word history and aligned output word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q   <= '0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            if (i_rx_valid) begin
                prev_q <= i_rx_data;
                data_q <= aligned_eff;
            end
            dvalid_q <= i_rx_valid && (state_q == LOCKED);
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = dvalid_q;
    assign o_offset      = offset_q;
    assign o_state       = state_q;
    assign o_locked      = locked_q;
    assign o_locked_soft = soft_q;
`ifdef BIT_ALIGNER_POLARITY_DETECT_EN
    assign o_polarity    = pol_q;
`else
    assign o_polarity    = 1'b0;
`endif

endmodule
